coord_project_pipe: RTL and testbench
=====================================

# coord_project_pipe

Parametrised, handshaked successor to the combinational 3D→2D camera projection in `cal_position`. Each accepted point (x, y, z) is projected through run-time-fixed intrinsics (FX, FY, CX, CY), divided by z with a shared-iteration sequential divider, scaled to the display raster, clamped, and flagged. It sits between the sound-source position solver and the overlay/drawing logic. It replaces the single-cycle divide with a multi-cycle datapath that closes timing.

## Interface
- XY_W, 32, signed width of x and y
- Z_W, 16, signed width of z
- K_W, 10, unsigned width of intrinsic constants
- FX, 185, focal x; FY, 185, focal y
- CX, 105, principal point x; CY, 77, principal point y
- RATE, 19, raster scale factor (4000/208)
- IMG_W, 4000, raster width; IMG_H, 2900, raster height
- OUT_W, 16, width of u/v
- Derived: NUM_W = XY_W + K_W (default 42)

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  point offered
- in_ready  out  1  block can accept
- x  in  XY_W  signed camera-frame x
- y  in  XY_W  signed camera-frame y
- z  in  Z_W  signed depth
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- u  out  OUT_W  raster column
- v  out  OUT_W  raster row
- in_frame  out  1  both coordinates within raster before clamping
- z_bad  out  1  z ≤ 0, result invalid

## Operation
- FSM states: IDLE, MUL, DIV, POST, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, register x, y, z → MUL.
- MUL: register nx=FX·x, ny=FY·y (signed, NUM_W). If z≤0 → POST with z_bad=1; else → DIV.
- DIV: two restoring dividers in lockstep on |nx|/z and |ny|/z, one quotient bit per cycle, NUM_W cycles. Apply the numerator sign to the quotient, giving truncation toward zero. → POST.
- POST: su=(qx+CX)·RATE, sv=(qy+CY)·RATE, signed, NUM_W+8 bits, no overflow possible.
- Clamp su to [0, IMG_W-1] and sv to [0, IMG_H-1].
- in_frame=1 only if neither coordinate was clamped.
- If z_bad: u=v=0, in_frame=0.
- Register outputs → OUT.
- OUT: out_valid=1. u, v and flags are held stable until out_valid&&out_ready, then → IDLE.
- in_ready=0 in every state except IDLE. There is no input/output overlap.

## Timing
- Reset values: out_valid=0, u=0, v=0, in_frame=0, z_bad=0, state=IDLE.
- in_ready=0 while rst=1. in_ready=1 on the first cycle after rst deasserts.
- Accept edge T (normal z): out_valid rises at T+NUM_W+3 (45 cycles at defaults).
- Accept edge T (z≤0): out_valid rises at T+3.
- Output handshake completes on the edge where out_valid&&out_ready. in_ready=1 the following cycle.
- Minimum throughput: one point per NUM_W+4 cycles with out_ready tied high.
- in_valid dropping mid-operation has no effect. x/y/z are only sampled at accept.
- rst asserted in any state aborts the operation. The partial result is discarded and the reset values apply on the next edge.
- Inputs presented while in_ready=0 are ignored and not queued.

## Test plan
- x=100, y=50, z=1000 → u=2337, v=1634, in_frame=1, z_bad=0; out_valid exactly 45 cycles after accept.
- x=-1000, y=0, z=100 → su=-33155 clamped, so u=0, v=1463, in_frame=0.
- x=10000, y=-1, z=10 → u=3999; qy=-18 gives v=1121; in_frame=0.
- z=0, then z=-5 (any x, y) → u=v=0, z_bad=1, in_frame=0; out_valid 3 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → u/v/flags stable, in_ready=0, a second in_valid is not accepted; release → transfer, in_ready=1 next cycle, second point accepted.
- Pulse rst during the DIV state at cycle T+20 → out_valid never asserts for that point; the next point is processed correctly with nominal latency.

Source files
------------

// File: rtl/coord_project_pipe.sv
// rtl/coord_project_pipe.sv - handshaked 3D->2D camera projection with sequential divide, raster scale and clamp
//
// Projects a camera-frame point (x, y, z) onto the display raster:
//   u = clamp(((FX*x)/z + CX) * RATE, 0, IMG_W-1)
//   v = clamp(((FY*y)/z + CY) * RATE, 0, IMG_H-1)
// Division truncates toward zero. One point is in flight at a time.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   point offered            in_ready   block can accept (IDLE only)
//   x, y       signed camera-frame x/y  z          signed depth
//   out_valid  result held              out_ready  consumer accepts
//   u, v       raster column / row
//   in_frame   neither coordinate was clamped
//   z_bad      z <= 0, u/v forced to zero
module coord_project_pipe #(
    parameter int XY_W  = 32,
    parameter int Z_W   = 16,
    parameter int K_W   = 10,
    parameter int FX    = 185,
    parameter int FY    = 185,
    parameter int CX    = 105,
    parameter int CY    = 77,
    parameter int RATE  = 19,
    parameter int IMG_W = 4000,
    parameter int IMG_H = 2900,
    parameter int OUT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [XY_W-1:0] x,
    input  logic signed [XY_W-1:0] y,
    input  logic signed [Z_W-1:0]  z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       u,
    output logic [OUT_W-1:0]       v,
    output logic                   in_frame,
    output logic                   z_bad
);

    localparam int NUM_W = XY_W + K_W;
    localparam int SC_W  = NUM_W + 8;
    localparam int CNT_W = $clog2(NUM_W + 1);

    localparam logic signed [NUM_W-1:0] FX_S   = NUM_W'(FX);
    localparam logic signed [NUM_W-1:0] FY_S   = NUM_W'(FY);
    localparam logic signed [SC_W-1:0]  CX_S   = SC_W'(CX);
    localparam logic signed [SC_W-1:0]  CY_S   = SC_W'(CY);
    localparam logic signed [SC_W-1:0]  RATE_S = SC_W'(RATE);
    localparam logic signed [SC_W-1:0]  UMAX_S = SC_W'(IMG_W - 1);
    localparam logic signed [SC_W-1:0]  VMAX_S = SC_W'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_POST,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [XY_W-1:0] r_x;
    logic signed [XY_W-1:0] r_y;
    logic signed [Z_W-1:0]  r_z;
    logic                   r_zbad;
    logic                   r_sx;
    logic                   r_sy;
    logic [Z_W-1:0]         r_div;
    // Quotient registers double as the dividend shift registers: the
    // dividend shifts out of the top while quotient bits shift in below.
    logic [NUM_W-1:0]       r_qx;
    logic [NUM_W-1:0]       r_qy;
    logic [Z_W-1:0]         r_rx;
    logic [Z_W-1:0]         r_ry;
    logic [CNT_W-1:0]       r_cnt;
    logic [OUT_W-1:0]       r_u;
    logic [OUT_W-1:0]       r_v;
    logic                   r_in_frame;
    logic                   r_z_bad;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_z_le0;
    logic signed [NUM_W-1:0] w_xe;
    logic signed [NUM_W-1:0] w_ye;
    logic signed [NUM_W-1:0] w_nx;
    logic signed [NUM_W-1:0] w_ny;
    logic [NUM_W-1:0]       w_ax;
    logic [NUM_W-1:0]       w_ay;
    logic [Z_W:0]           w_trial_x;
    logic [Z_W:0]           w_trial_y;
    logic                   w_ge_x;
    logic                   w_ge_y;
    logic [Z_W:0]           w_sub_x;
    logic [Z_W:0]           w_sub_y;
    logic signed [NUM_W-1:0] w_qx;
    logic signed [NUM_W-1:0] w_qy;
    logic signed [SC_W-1:0] w_su;
    logic signed [SC_W-1:0] w_sv;
    logic                   w_u_clamped;
    logic                   w_v_clamped;
    logic [OUT_W-1:0]       w_u;
    logic [OUT_W-1:0]       w_v;

    // in_ready is gated by rst so it reads 0 throughout reset.
    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = in_valid && w_in_ready;
    assign in_ready   = w_in_ready;
    assign out_valid  = (r_state == S_OUT);
    assign u          = r_u;
    assign v          = r_v;
    assign in_frame   = r_in_frame;
    assign z_bad      = r_z_bad;

    assign w_z_le0 = r_z[Z_W-1] || (r_z == '0);

    // Projection numerators; products fit NUM_W signed since |x| <= 2^(XY_W-1)
    // and the intrinsics are below 2^K_W.
    assign w_xe = {{K_W{r_x[XY_W-1]}}, r_x};
    assign w_ye = {{K_W{r_y[XY_W-1]}}, r_y};
    assign w_nx = FX_S * w_xe;
    assign w_ny = FY_S * w_ye;
    assign w_ax = w_nx[NUM_W-1] ? -w_nx : w_nx;
    assign w_ay = w_ny[NUM_W-1] ? -w_ny : w_ny;

    // One restoring-division step per lane. Remainder stays below the
    // divisor, so Z_W bits hold it and the trial needs one extra bit.
    assign w_trial_x = {r_rx, r_qx[NUM_W-1]};
    assign w_trial_y = {r_ry, r_qy[NUM_W-1]};
    assign w_ge_x    = (w_trial_x >= {1'b0, r_div});
    assign w_ge_y    = (w_trial_y >= {1'b0, r_div});
    assign w_sub_x   = w_trial_x - {1'b0, r_div};
    assign w_sub_y   = w_trial_y - {1'b0, r_div};

    // Signed quotients, offset, scale, clamp.
    assign w_qx = r_sx ? -r_qx : r_qx;
    assign w_qy = r_sy ? -r_qy : r_qy;
    assign w_su = ($signed({{8{w_qx[NUM_W-1]}}, w_qx}) + CX_S) * RATE_S;
    assign w_sv = ($signed({{8{w_qy[NUM_W-1]}}, w_qy}) + CY_S) * RATE_S;

    always_comb begin
        w_u_clamped = 1'b0;
        w_v_clamped = 1'b0;
        w_u         = w_su[OUT_W-1:0];
        w_v         = w_sv[OUT_W-1:0];
        if (w_su[SC_W-1]) begin
            w_u         = '0;
            w_u_clamped = 1'b1;
        end else if (w_su > UMAX_S) begin
            w_u         = OUT_W'(IMG_W - 1);
            w_u_clamped = 1'b1;
        end
        if (w_sv[SC_W-1]) begin
            w_v         = '0;
            w_v_clamped = 1'b1;
        end else if (w_sv > VMAX_S) begin
            w_v         = OUT_W'(IMG_H - 1);
            w_v_clamped = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_MUL;
            S_MUL:  w_next = w_z_le0 ? S_POST : S_DIV;
            S_DIV:  if (r_cnt == CNT_W'(NUM_W - 1)) w_next = S_POST;
            S_POST: w_next = S_OUT;
            S_OUT:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_u        <= '0;
            r_v        <= '0;
            r_in_frame <= 1'b0;
            r_z_bad    <= 1'b0;
            r_zbad     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x <= x;
                        r_y <= y;
                        r_z <= z;
                    end
                end
                S_MUL: begin
                    r_zbad <= w_z_le0;
                    r_sx   <= w_nx[NUM_W-1];
                    r_sy   <= w_ny[NUM_W-1];
                    r_qx   <= w_ax;
                    r_qy   <= w_ay;
                    r_rx   <= '0;
                    r_ry   <= '0;
                    r_div  <= r_z;
                    r_cnt  <= '0;
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_rx  <= w_ge_x ? w_sub_x[Z_W-1:0] : w_trial_x[Z_W-1:0];
                    r_ry  <= w_ge_y ? w_sub_y[Z_W-1:0] : w_trial_y[Z_W-1:0];
                    r_qx  <= {r_qx[NUM_W-2:0], w_ge_x};
                    r_qy  <= {r_qy[NUM_W-2:0], w_ge_y};
                end
                S_POST: begin
                    r_z_bad <= r_zbad;
                    if (r_zbad) begin
                        r_u        <= '0;
                        r_v        <= '0;
                        r_in_frame <= 1'b0;
                    end else begin
                        r_u        <= w_u;
                        r_v        <= w_v;
                        r_in_frame <= !w_u_clamped && !w_v_clamped;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coord_project_pipe.sv
// tb/tb_coord_project_pipe.sv - scoreboard bench for coord_project_pipe
module tb_coord_project_pipe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] x = '0;
    logic signed [31:0] y = '0;
    logic signed [15:0] z = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [15:0]        u;
    logic [15:0]        v;
    logic               in_frame;
    logic               z_bad;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int u;
        int v;
        bit f;
        bit b;
        int lat;
        int acc;
    } exp_t;
    exp_t q[$];

    coord_project_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .u         (u),
        .v         (v),
        .in_frame  (in_frame),
        .z_bad     (z_bad)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: latency on the rising out_valid, field compare on handshake.
    bit prev_ov = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("latency", cyc - q[0].acc, q[0].lat);
                end
            end
            if (!rst && out_valid && out_ready && q.size() > 0) begin
                chk("u", int'(u), q[0].u);
                chk("v", int'(v), q[0].v);
                chk("in_frame", int'(in_frame), int'(q[0].f));
                chk("z_bad", int'(z_bad), int'(q[0].b));
                void'(q.pop_front());
            end
            prev_ov = out_valid && !rst;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic signed [31:0] px, input logic signed [31:0] py,
                        input logic signed [15:0] pz, input int eu, input int ev,
                        input bit ef, input bit eb, input int elat, input bit push);
        exp_t e;
        int k;
        x = px;
        y = py;
        z = pz;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else if (push) begin
            e.u = eu; e.v = ev; e.f = ef; e.b = eb; e.lat = elat; e.acc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int k = 0;
        while (q.size() > 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int k;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_u", int'(u), 0);
        chk("rst_v", int'(v), 0);
        chk("rst_in_frame", int'(in_frame), 0);
        chk("rst_z_bad", int'(z_bad), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", int'(in_ready), 1);

        send(32'sd100, 32'sd50, 16'sd1000, 2337, 1634, 1'b1, 1'b0, 45, 1'b1);
        wait_empty();
        send(-32'sd1000, 32'sd0, 16'sd100, 0, 1463, 1'b0, 1'b0, 45, 1'b1);
        wait_empty();
        send(32'sd10000, -32'sd1, 16'sd10, 3999, 1121, 1'b0, 1'b0, 45, 1'b1);
        wait_empty();
        send(32'sd77, -32'sd9, 16'sd0, 0, 0, 1'b0, 1'b1, 3, 1'b1);
        wait_empty();
        send(-32'sd3, 32'sd400, -16'sd5, 0, 0, 1'b0, 1'b1, 3, 1'b1);
        wait_empty();

        // Backpressure: hold result, offer a second point that must be ignored.
        out_ready = 1'b0;
        send(32'sd100, 32'sd50, 16'sd1000, 2337, 1634, 1'b1, 1'b0, 45, 1'b1);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        x = -32'sd1000; y = 32'sd0; z = 16'sd100;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_u", int'(u), 2337);
            chk("bp_v", int'(v), 1634);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_xfer", int'(in_ready), 1);
        send(-32'sd1000, 32'sd0, 16'sd100, 0, 1463, 1'b0, 1'b0, 45, 1'b1);
        wait_empty();

        // Reset mid-divide: the point must vanish.
        send(32'sd100, 32'sd50, 16'sd1000, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", int'(seen), 0);
        chk("abort_u_cleared", int'(u), 0);
        send(32'sd10000, -32'sd1, 16'sd10, 3999, 1121, 1'b0, 1'b0, 45, 1'b1);
        wait_empty();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
